// File: rtl/count_update.sv
// count_update: read-modify-write engine for the Gibbs-sampler count tables.
// Moves one token from its old topic to its new topic, or only adds it in init mode.
module count_update #(
  parameter int LOG2K  = 7,
  parameter int WORD_W = 11,
  parameter int DOC_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_tok_valid,
  output logic              o_tok_ready,
  input  logic              i_init,
  input  logic [WORD_W-1:0] i_word,
  input  logic [DOC_W-1:0]  i_doc,
  input  logic [LOG2K-1:0]  i_old_topic,
  input  logic [LOG2K-1:0]  i_new_topic,
  output logic              o_done,
  output logic              o_err,
  output logic              o_read_req,
  output logic [31:0]       o_nw_raddr,
  output logic [31:0]       o_nd_raddr,
  output logic [31:0]       o_nwsum_raddr,
  output logic [31:0]       o_ndsum_raddr,
  input  logic              i_read_ack,
  input  logic [31:0]       i_nw_rdata,
  input  logic [31:0]       i_nd_rdata,
  input  logic [31:0]       i_nwsum_rdata,
  input  logic [31:0]       i_ndsum_rdata,
  output logic              o_wen,
  output logic [31:0]       o_nw_waddr,
  output logic [31:0]       o_nd_waddr,
  output logic [31:0]       o_nwsum_waddr,
  output logic [31:0]       o_ndsum_waddr,
  output logic [31:0]       o_nw_wdata,
  output logic [31:0]       o_nd_wdata,
  output logic [31:0]       o_nwsum_wdata,
  output logic [31:0]       o_ndsum_wdata,
  input  logic              i_write_ack
);

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, WWAIT} state_t;
  typedef enum logic {PH_OLD, PH_NEW} phase_t;

  state_t            state;
  phase_t            ph;
  logic [WORD_W-1:0] word_q;
  logic [DOC_W-1:0]  doc_q;
  logic [LOG2K-1:0]  new_q;
  logic              init_q;

  // Lane order in the packed words: [3]=nw, [2]=nd, [1]=nwsum, [0]=ndsum.
  logic [3:0][31:0]  addr_q;
  logic [3:0][31:0]  wdata_q;
  logic [3:0][31:0]  wdata_next;
  logic [3:0]        sat_lane;
  logic              same_topic;

  function automatic logic [3:0][31:0] pack_addr(input logic [WORD_W-1:0] w,
                                                 input logic [DOC_W-1:0]  d,
                                                 input logic [LOG2K-1:0]  t);
    return {32'({w, t}), 32'({d, t}), 32'(t), 32'(d)};
  endfunction

  // Returns {saturated, result} for a saturating +1 (up) or -1 (!up).
  function automatic logic [32:0] sat_step(input logic [31:0] v, input logic up);
    if (up) return (v == '1) ? {1'b1, v} : {1'b0, v + 32'd1};
    else    return (v == '0) ? {1'b1, v} : {1'b0, v - 32'd1};
  endfunction

  assign same_topic = (i_old_topic == i_new_topic);

  always_comb begin
    wdata_next = '0;
    sat_lane   = '0;
    {sat_lane[3], wdata_next[3]} = sat_step(i_nw_rdata,    ph == PH_NEW);
    {sat_lane[2], wdata_next[2]} = sat_step(i_nd_rdata,    ph == PH_NEW);
    {sat_lane[1], wdata_next[1]} = sat_step(i_nwsum_rdata, ph == PH_NEW);
    if (ph == PH_NEW && init_q)
      {sat_lane[0], wdata_next[0]} = sat_step(i_ndsum_rdata, 1'b1);
    else
      wdata_next[0] = i_ndsum_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ph          <= PH_OLD;
      word_q      <= '0;
      doc_q       <= '0;
      new_q       <= '0;
      init_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      o_tok_ready <= 1'b1;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_read_req  <= 1'b0;
      o_wen       <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_read_req <= 1'b0;
      o_wen      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_tok_valid) begin
            word_q <= i_word;
            doc_q  <= i_doc;
            new_q  <= i_new_topic;
            init_q <= i_init;
            ph     <= (i_init || same_topic) ? PH_NEW : PH_OLD;
            // A move onto the same topic is a no-op on every table.
            if (!i_init && same_topic) begin
              o_done <= 1'b1;
            end else begin
              addr_q      <= pack_addr(i_word, i_doc, i_init ? i_new_topic : i_old_topic);
              state       <= RD;
              o_read_req  <= 1'b1;
              o_tok_ready <= 1'b0;
            end
          end
        end
        RD: state <= RWAIT;
        RWAIT: begin
          if (i_read_ack) begin
            wdata_q <= wdata_next;
            o_err   <= o_err | (|sat_lane);
            state   <= WR;
            o_wen   <= 1'b1;
          end
        end
        WR: state <= WWAIT;
        WWAIT: begin
          if (i_write_ack) begin
            if (ph == PH_OLD) begin
              ph         <= PH_NEW;
              addr_q     <= pack_addr(word_q, doc_q, new_q);
              state      <= RD;
              o_read_req <= 1'b1;
            end else begin
              state       <= IDLE;
              o_done      <= 1'b1;
              o_tok_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_nw_raddr    = addr_q[3];
  assign o_nd_raddr    = addr_q[2];
  assign o_nwsum_raddr = addr_q[1];
  assign o_ndsum_raddr = addr_q[0];
  assign o_nw_waddr    = addr_q[3];
  assign o_nd_waddr    = addr_q[2];
  assign o_nwsum_waddr = addr_q[1];
  assign o_ndsum_waddr = addr_q[0];
  assign o_nw_wdata    = wdata_q[3];
  assign o_nd_wdata    = wdata_q[2];
  assign o_nwsum_wdata = wdata_q[1];
  assign o_ndsum_wdata = wdata_q[0];

endmodule

// File: doc/count_update.md
# count_update

Read-modify-write engine for the Gibbs-sampler count tables: word-topic (nw), doc-topic (nd), per-topic totals (nwsum) and per-document totals (ndsum). It sits directly upstream of the local count memory. It accepts one token reassignment at a time from the sampler (word, doc, old topic, new topic) and drives the memory's read request/ack and write-enable/ack ports. It decrements the counts of the old topic and increments those of the new topic, or increments only during initialisation.

## Interface
- LOG2K, 7, log2 of topic count K; topic index width
- WORD_W, 11, word index width; nw address = {word, topic}
- DOC_W, 8, document index width; nd address = {doc, topic}, ndsum address = doc
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_tok_valid  in  1  token request valid
- o_tok_ready  out  1  engine idle, can accept a token
- i_init  in  1  1 = init mode (increment new topic only); 0 = move mode
- i_word  in  WORD_W  word index
- i_doc  in  DOC_W  document index
- i_old_topic  in  LOG2K  current topic (ignored in init mode)
- i_new_topic  in  LOG2K  newly sampled topic
- o_done  out  1  one-cycle pulse: token update fully written
- o_err  out  1  sticky: a saturation occurred (underflow or overflow)
- o_read_req  out  1  memory read request (one-cycle pulse)
- o_nw_raddr, o_nd_raddr, o_nwsum_raddr, o_ndsum_raddr  out  32 each  read addresses, zero-extended
- i_read_ack  in  1  read data valid
- i_nw_rdata, i_nd_rdata, i_nwsum_rdata, i_ndsum_rdata  in  32 each  read data; high-Z when ack low
- o_wen  out  1  write enable for all four tables (one-cycle pulse)
- o_nw_waddr, o_nd_waddr, o_nwsum_waddr, o_ndsum_waddr  out  32 each  write addresses
- o_nw_wdata, o_nd_wdata, o_nwsum_wdata, o_ndsum_wdata  out  32 each  write data
- i_write_ack  in  1  write completed

## Operation
- States: IDLE, RD, RWAIT, WR, WWAIT; phase register PH ∈ {OLD, NEW}.
- IDLE: o_tok_ready=1. On i_tok_valid, latch all token fields. Set PH=NEW if i_init or old==new, else PH=OLD. Go to RD. When old==new in move mode, skip memory traffic entirely: o_done pulses next cycle and the state stays IDLE.
- RD: o_read_req=1 for exactly one cycle. Addresses use topic = old (PH=OLD) or new (PH=NEW). Go to RWAIT.
- Read and write addresses are registered and held stable from RD until leaving WWAIT, because the memory samples them every cycle.
- RWAIT: wait for i_read_ack. Capture all four rdata only in the ack cycle (data is high-Z otherwise). Compute write data and go to WR.
- Arithmetic, 32-bit unsigned:
  - PH=OLD: nw, nd, nwsum -1, saturating at 0; ndsum written back unchanged.
  - PH=NEW: nw, nd, nwsum +1, saturating at 0xFFFFFFFF; ndsum +1 (saturating) in init mode only, else unchanged.
  - Any saturation sets o_err.
- WR: o_wen=1 for one cycle, writing all four tables in the same cycle. Go to WWAIT.
- WWAIT: wait for i_write_ack. If PH=OLD, set PH=NEW and go to RD. If PH=NEW, go to IDLE with o_done=1 in that first IDLE cycle.
- i_tok_valid while not ready is ignored (no queuing); the sampler holds valid until ready.
- o_err clears only on reset.

## Timing
- Reset values: o_tok_ready=1, o_done=0, o_err=0, o_read_req=0, o_wen=0. All address and wdata outputs are 0. State is IDLE, PH=OLD.
- Accept edge = cycle 0.
- Per phase, against memory with 2-cycle read-ack latency and 1-cycle write-ack latency:
  - read_req in cycle 1;
  - ack in cycle 3;
  - wen in cycle 4;
  - write_ack in cycle 5.
- Move token: o_done in cycle 11, next token can be accepted in cycle 11.
- Init token: o_done in cycle 6.
- old==new move token: o_done in cycle 1.
- Acks are waited on indefinitely; a longer memory latency only stretches RWAIT/WWAIT.
- Reset asserted mid-operation aborts immediately. Any partially applied phase-OLD write is not rolled back; the sampler re-initialises.

## Test plan
- Init: memory zeroed; init token w=5,d=3,new=9 -> nw[{5,9}], nd[{3,9}], nwsum[9], ndsum[3] all =1; o_done in cycle 6; read_req and wen each high exactly 1 cycle.
- Move: counts nw[{5,9}]=4, nd[{3,9}]=2, nwsum[9]=10, ndsum[3]=7; move 9->20 -> 3, 1, 9, ndsum 7; topic-20 entries each +1; ndsum[3] still 7; o_done in cycle 11.
- old==new=9 in move mode -> no read_req/wen, o_done in cycle 1, counts unchanged.
- Underflow: nwsum[4]=0, move 4->6 -> nwsum[4] stays 0, o_err=1 and remains set across later tokens until rst_n.
- Back-pressure and latency: i_tok_valid held continuously with 4 queued tokens, memory acks delayed by 5 extra cycles -> tokens processed in order, addresses stable through each wait, one o_done per token.
- Reset during RWAIT of phase OLD -> all outputs at reset values next cycle, o_tok_ready=1, no wen issued.
